// File: rtl/video_out_timing.sv
// Video output timing generator: reads pixels from a show-ahead FIFO and produces
// line/frame valids. Optional underflow cycle counter: `define VIDEO_OUT_UNDERFLOW_CNT_EN.
module video_out_timing #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_BLANK  = 160,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_BLANK  = 45
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       enable,
   input  logic       empty,
   input  logic [7:0] data_in,
   output logic       r_ack,
   output logic       line_valid,
   output logic       frame_valid,
   output logic [7:0] pixel_out,
   output logic       end_of_frame,
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
   output logic [15:0] underflow_cnt,
`endif
   output logic       underflow
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
   localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        r_state, w_state_d;
   logic [HW-1:0] r_h_cnt, w_h_cnt_d;
   logic [VW-1:0] r_v_cnt, w_v_cnt_d;
   logic          r_line_valid, r_frame_valid, r_end_of_frame, r_underflow;
   logic [7:0]    r_pixel_out;
   logic          w_active, w_frame_act, w_last;

   always_comb begin
      w_state_d   = r_state;
      w_h_cnt_d   = r_h_cnt;
      w_v_cnt_d   = r_v_cnt;
      w_active    = (r_state == RUN) && (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
      w_frame_act = (r_state == RUN) && (r_v_cnt < V_ACT);
      w_last      = (r_state == RUN) && (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
      r_ack       = w_active && !empty && !RST;

      unique case (r_state)
         IDLE: begin
            w_h_cnt_d = '0;
            w_v_cnt_d = '0;
            if (enable && !empty) w_state_d = RUN;
         end
         RUN: begin
            if (r_h_cnt == H_LAST) begin
               w_h_cnt_d = '0;
               if (r_v_cnt == V_LAST) begin
                  w_v_cnt_d = '0;
                  // Only a frame boundary may stop the raster.
                  if (!enable || empty) w_state_d = IDLE;
               end else begin
                  w_v_cnt_d = r_v_cnt + 1'b1;
               end
            end else begin
               w_h_cnt_d = r_h_cnt + 1'b1;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         r_state        <= IDLE;
         r_h_cnt        <= '0;
         r_v_cnt        <= '0;
         r_line_valid   <= 1'b0;
         r_frame_valid  <= 1'b0;
         r_pixel_out    <= 8'h00;
         r_end_of_frame <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_state        <= w_state_d;
         r_h_cnt        <= w_h_cnt_d;
         r_v_cnt        <= w_v_cnt_d;
         // line_valid keeps the timing even when the FIFO runs dry; the pixel is zeroed.
         r_line_valid   <= w_active;
         r_frame_valid  <= w_frame_act;
         r_pixel_out    <= r_ack ? data_in : 8'h00;
         r_end_of_frame <= w_last;
         r_underflow    <= r_underflow | (w_active & empty);
      end
   end

`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
   logic [15:0] r_underflow_cnt;

   always_ff @(posedge clk) begin
      if (RST) begin
         r_underflow_cnt <= 16'h0000;
      end else if (w_active && empty && (r_underflow_cnt != 16'hFFFF)) begin
         r_underflow_cnt <= r_underflow_cnt + 16'h0001;
      end
   end

   assign underflow_cnt = r_underflow_cnt;
`endif

   assign line_valid   = r_line_valid;
   assign frame_valid  = r_frame_valid;
   assign pixel_out    = r_pixel_out;
   assign end_of_frame = r_end_of_frame;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_video_out_timing.sv
// Bench for video_out_timing with an 8/4/4/2 raster: per-cycle scoreboard of the
// registered outputs plus directed checks of each scenario.
module tb_video_out_timing;

   localparam int HA = 8;
   localparam int HB = 4;
   localparam int VA = 4;
   localparam int VB = 2;
   localparam int H_LAST = HA + HB - 1;
   localparam int V_LAST = VA + VB - 1;

   logic       clk = 1'b0;
   logic       RST;
   logic       enable;
   logic       empty;
   logic [7:0] data_in;
   logic       r_ack;
   logic       line_valid;
   logic       frame_valid;
   logic [7:0] pixel_out;
   logic       end_of_frame;
   logic       underflow;
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
   logic [15:0] underflow_cnt;
`endif

   video_out_timing #(
      .H_ACTIVE (HA),
      .H_BLANK  (HB),
      .V_ACTIVE (VA),
      .V_BLANK  (VB)
   ) dut (
      .clk          (clk),
      .RST          (RST),
      .enable       (enable),
      .empty        (empty),
      .data_in      (data_in),
      .r_ack        (r_ack),
      .line_valid   (line_valid),
      .frame_valid  (frame_valid),
      .pixel_out    (pixel_out),
      .end_of_frame (end_of_frame),
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
      .underflow_cnt(underflow_cnt),
`endif
      .underflow    (underflow)
   );

   always #20 clk = ~clk;

   typedef struct packed {
      logic        lv;
      logic        fv;
      logic [7:0]  pix;
      logic        eof;
      logic        uf;
      logic [15:0] ucnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference raster state, advanced once per clock.
   bit m_run = 1'b0;
   int m_h   = 0;
   int m_v   = 0;
   bit m_uf  = 1'b0;
   int m_ucnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      exp_t e;
      bit   act;
      bit   ack;
      #1;
      act = m_run && (m_h < HA) && (m_v < VA);
      ack = act && !empty && !RST;
      chk("r_ack", 32'(r_ack), 32'(ack));
      e = '0;
      if (!RST) begin
         e.lv   = act;
         e.fv   = m_run && (m_v < VA);
         e.pix  = ack ? data_in : 8'h00;
         e.eof  = m_run && (m_h == H_LAST) && (m_v == V_LAST);
         e.uf   = m_uf || (act && empty);
         e.ucnt = (act && empty && m_ucnt < 65535) ? 16'(m_ucnt + 1) : 16'(m_ucnt);
      end
      sb_q.push_back(e);
      m_uf   = e.uf;
      m_ucnt = int'(e.ucnt);
      if (RST) begin
         m_run = 1'b0; m_h = 0; m_v = 0;
      end else if (!m_run) begin
         m_run = enable && !empty; m_h = 0; m_v = 0;
      end else if (m_h == H_LAST) begin
         m_h = 0;
         if (m_v == V_LAST) begin
            m_v = 0;
            m_run = enable && !empty;
         end else begin
            m_v++;
         end
      end else begin
         m_h++;
      end
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("line_valid", 32'(line_valid), 32'(e.lv));
      chk("frame_valid", 32'(frame_valid), 32'(e.fv));
      chk("pixel_out", 32'(pixel_out), 32'(e.pix));
      chk("end_of_frame", 32'(end_of_frame), 32'(e.eof));
      chk("underflow", 32'(underflow), 32'(e.uf));
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
      chk("underflow_cnt", 32'(underflow_cnt), 32'(e.ucnt));
`endif
      // Show-ahead FIFO: head advances on each pop.
      if (ack) data_in = data_in + 8'h01;
   endtask

   initial begin
      int lv_cnt;
      int eof_at;
      int fv_cnt;
      int eof_cnt;
      int rise_at;
      bit found;

      RST = 1'b1; enable = 1'b0; empty = 1'b1; data_in = 8'h10;
      tick(); tick();
      chk("reset_lv", 32'(line_valid), 32'd0);
      chk("reset_uf", 32'(underflow), 32'd0);
      RST = 1'b0;
      tick(); tick();

      // Full FIFO, continuous enable: 4-line frame, eof after 72 raster cycles.
      enable = 1'b1; empty = 1'b0;
      lv_cnt = 0; eof_at = 0;
      for (int i = 1; i <= 80; i++) begin
         tick();
         if (i <= 73 && line_valid) lv_cnt++;
         if (end_of_frame && eof_at == 0) eof_at = i;
         if (i == 73) chk("pixels_consumed", 32'(data_in), 32'h30);
      end
      chk("frame1_lv_count", 32'(lv_cnt), 32'd32);
      chk("frame1_eof_at", 32'(eof_at), 32'd73);

      // Underflow for 3 active cycles on line 1.
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (m_run && m_h == 2 && m_v == 1) found = 1'b1;
         else tick();
      end
      chk("reach_uf_point", 32'(found), 32'd1);
      empty = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("uf_line_valid", 32'(line_valid), 32'd1);
         chk("uf_pixel_zero", 32'(pixel_out), 32'd0);
      end
      chk("uf_set", 32'(underflow), 32'd1);
      empty = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("uf_sticky", 32'(underflow), 32'd1);
`ifdef VIDEO_OUT_UNDERFLOW_CNT_EN
      chk("uf_count", 32'(underflow_cnt), 32'd3);
`endif

      // Drop enable on line 2: frame completes, then idle.
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (m_run && m_h == 0 && m_v == 2) found = 1'b1;
         else tick();
      end
      chk("reach_line2", 32'(found), 32'd1);
      enable = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (end_of_frame) found = 1'b1;
      end
      chk("stop_eof_seen", 32'(found), 32'd1);
      fv_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (frame_valid) fv_cnt++;
      end
      chk("idle_fv_low", 32'(fv_cnt), 32'd0);

      // Reset mid-frame at h=5, v=1.
      enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (m_run && m_h == 5 && m_v == 1) found = 1'b1;
         else tick();
      end
      chk("reach_rst_point", 32'(found), 32'd1);
      RST = 1'b1;
      tick();
      chk("rst_lv", 32'(line_valid), 32'd0);
      chk("rst_fv", 32'(frame_valid), 32'd0);
      chk("rst_pix", 32'(pixel_out), 32'd0);
      chk("rst_eof", 32'(end_of_frame), 32'd0);
      chk("rst_uf", 32'(underflow), 32'd0);
      RST = 1'b0;
      eof_cnt = 0; rise_at = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (end_of_frame) eof_cnt++;
         if (line_valid && rise_at == 0) rise_at = i;
      end
      chk("rst_no_eof", 32'(eof_cnt), 32'd0);
      chk("restart_lv_at", 32'(rise_at), 32'd2);

      // enable with empty FIFO in IDLE: wait for data, fv 2 cycles after.
      RST = 1'b1;
      tick();
      RST = 1'b0; enable = 1'b1; empty = 1'b1;
      fv_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (frame_valid) fv_cnt++;
      end
      chk("empty_no_start", 32'(fv_cnt), 32'd0);
      empty = 1'b0;
      rise_at = 0;
      for (int i = 1; i <= 10 && rise_at == 0; i++) begin
         tick();
         if (frame_valid) rise_at = i;
      end
      chk("start_fv_at", 32'(rise_at), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
